// File: rtl/debounce_edge_detect.sv
// Two-flop synchroniser followed by a four-state stability filter.
// Emits the clean level plus one-cycle rise/fall strobes.
module debounce_edge_detect #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  // Next-state logic: a bounce in a WAIT state drops back to the originating IDLE state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE_LOW;
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = CNT_ZERO;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE_HIGH;
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = CNT_ZERO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = CNT_ZERO;
        level_d = 1'b0;
      end
    endcase
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  // Synchroniser, FSM and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= d;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign q    = level_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect; outputs checked as {q,rise,fall,busy}
// one time unit after each rising edge.
module tb_debounce_edge_detect;

  logic clk = 1'b0;
  logic reset_n;
  logic d;
  logic q, rise, fall, busy;
  logic [3:0] obs;
  int n_tests = 0;
  int n_fail  = 0;

  debounce_edge_detect #(.STABLE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .d(d),
    .q(q), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clk = ~clk;
  assign obs = {q, rise, fall, busy};

  // Advance to the next rising edge, then compare outputs 1 time unit later.
  task automatic edge_chk(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {q,rise,fall,busy}=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    d       = 1'b1;
    #1;
    // Test 1: reset held for two edges with d=1
    edge_chk("rst_e1", 4'b0000);
    edge_chk("rst_e2", 4'b0000);

    reset_n = 1'b1;
    d       = 1'b0;
    edge_chk("idle_a", 4'b0000);
    edge_chk("idle_b", 4'b0000);
    edge_chk("idle_c", 4'b0000);

    // Test 2: clean rise
    d = 1'b1;
    edge_chk("rise_e1", 4'b0000);
    edge_chk("rise_e2", 4'b0000);
    edge_chk("rise_e3", 4'b0001);
    edge_chk("rise_e4", 4'b0001);
    edge_chk("rise_e5", 4'b0001);
    edge_chk("rise_e6", 4'b1100);
    edge_chk("rise_e7", 4'b1000);
    for (int i = 0; i < 12; i++) edge_chk("hold_high", 4'b1000);

    // Test 4: clean fall
    d = 1'b0;
    edge_chk("fall_e1", 4'b1000);
    edge_chk("fall_e2", 4'b1000);
    edge_chk("fall_e3", 4'b1001);
    edge_chk("fall_e4", 4'b1001);
    edge_chk("fall_e5", 4'b1001);
    edge_chk("fall_e6", 4'b0010);
    edge_chk("fall_e7", 4'b0000);

    // Test 3: two-edge glitch is rejected
    d = 1'b1;
    edge_chk("glitch_e1", 4'b0000);
    edge_chk("glitch_e2", 4'b0000);
    d = 1'b0;
    edge_chk("glitch_e3", 4'b0001);
    edge_chk("glitch_e4", 4'b0001);
    edge_chk("glitch_e5", 4'b0000);
    for (int i = 0; i < 6; i++) edge_chk("glitch_after", 4'b0000);

    // Test 5: bounce 1,0,1 then hold 1
    d = 1'b1;
    edge_chk("bounce_e1", 4'b0000);
    d = 1'b0;
    edge_chk("bounce_e2", 4'b0000);
    d = 1'b1;
    edge_chk("bounce_e3", 4'b0001);
    edge_chk("bounce_e4", 4'b0000);
    edge_chk("bounce_e5", 4'b0001);
    edge_chk("bounce_e6", 4'b0001);
    edge_chk("bounce_e7", 4'b0001);
    edge_chk("bounce_e8", 4'b1100);
    for (int i = 0; i < 5; i++) edge_chk("bounce_after", 4'b1000);

    d = 1'b0;
    for (int i = 0; i < 5; i++) edge_chk("back_low_wait", (i < 2) ? 4'b1000 : 4'b1001);
    edge_chk("back_low_fall", 4'b0010);
    edge_chk("back_low_idle", 4'b0000);

    // Test 6: reset while WAIT_HIGH with cnt=2
    d = 1'b1;
    edge_chk("abort_e1", 4'b0000);
    edge_chk("abort_e2", 4'b0000);
    edge_chk("abort_e3", 4'b0001);
    edge_chk("abort_e4", 4'b0001);
    reset_n = 1'b0;
    edge_chk("abort_rst", 4'b0000);
    reset_n = 1'b1;
    edge_chk("requal_e1", 4'b0000);
    edge_chk("requal_e2", 4'b0000);
    edge_chk("requal_e3", 4'b0001);
    edge_chk("requal_e4", 4'b0001);
    edge_chk("requal_e5", 4'b0001);
    edge_chk("requal_e6", 4'b1100);
    edge_chk("requal_e7", 4'b1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
